// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared FSM encodings and helpers for the hazard controller
package pipe_hazard_ctrl_pkg;
  localparam int REG_W = 5;
  typedef enum logic [1:0] {
    HZ_RUN        = 2'd0,
    HZ_MEM_WAIT   = 2'd1,
    HZ_FLUSH_PEND = 2'd2
  } hz_state_e;
  function automatic logic src_hit(input logic uses, input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst);
    return uses & (src == dst);
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use compare between the ID sources and the EX load destination
// Ports: rs1/rs2 + uses_rs1/uses_rs2 (ID sources), mem_read/rd (EX load), load_use (hazard present)
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             uses_rs1,
  input  logic             uses_rs2,
  input  logic             mem_read,
  input  logic [REG_W-1:0] rd,
  output logic             load_use
);
  // x0 is hard-wired zero, so a load targeting it never creates a dependency
  assign load_use = mem_read & (rd != '0) & (src_hit(uses_rs1, rs1, rd) | src_hit(uses_rs2, rs2, rd));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/bubble/flush strobe generator for load-use, redirect and memory-wait hazards
// Inputs: ID source regs/uses, EX load info and redirect, MEM request/ready.
// Outputs: pc_hold, if_id_hold, if_id_flush, id_ex_bubble, ex_mem_hold, mem_wb_bubble,
//          saturating stall_cnt/flush_cnt, sticky mem_timeout_err.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ID_rs1_addr,
  input  logic [REG_W-1:0] ID_rs2_addr,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic             EX_mem_read,
  input  logic [REG_W-1:0] EX_reg_addr,
  input  logic             EX_redirect,
  input  logic             MEM_req,
  input  logic             MEM_ready,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_hold,
  output logic             mem_wb_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout_err
);
  localparam logic [CNT_W-1:0] TO = CNT_W'(MEM_TIMEOUT);
  hz_state_e state, state_n;
  logic flush_pend, fp_n, load_use, mem_stall, flush, lu_stall;
  logic [CNT_W-1:0] wait_cnt, wc_n;
  hazard_detect u_hd (
    .rs1      (ID_rs1_addr),
    .rs2      (ID_rs2_addr),
    .uses_rs1 (ID_uses_rs1),
    .uses_rs2 (ID_uses_rs2),
    .mem_read (EX_mem_read),
    .rd       (EX_reg_addr),
    .load_use (load_use)
  );
  assign mem_stall = MEM_req & ~MEM_ready;
  // A redirect seen while memory is stalled (including the release cycle) is
  // remembered and replayed as a single FLUSH_PEND cycle once the pipe moves.
  always_comb begin
    state_n  = state;
    fp_n     = flush_pend;
    wc_n     = '0;
    flush    = 1'b0;
    lu_stall = 1'b0;
    case (state)
      HZ_RUN:
        if (mem_stall) begin
          state_n = HZ_MEM_WAIT;
          fp_n    = EX_redirect;
        end else if (EX_redirect) flush = 1'b1;
        else lu_stall = load_use;
      HZ_MEM_WAIT: begin
        fp_n = flush_pend | EX_redirect;
        if (mem_stall) wc_n = (wait_cnt == TO) ? wait_cnt : wait_cnt + CNT_W'(1);
        else state_n = fp_n ? HZ_FLUSH_PEND : HZ_RUN;
      end
      HZ_FLUSH_PEND:
        if (mem_stall) begin
          state_n = HZ_MEM_WAIT;
          fp_n    = 1'b1;
        end else begin
          flush   = 1'b1;
          fp_n    = 1'b0;
          state_n = HZ_RUN;
        end
      default: state_n = HZ_RUN;
    endcase
  end
  assign pc_hold       = mem_stall | lu_stall;
  assign if_id_hold    = mem_stall | lu_stall;
  assign if_id_flush   = flush;
  assign id_ex_bubble  = flush | lu_stall;
  assign ex_mem_hold   = mem_stall;
  assign mem_wb_bubble = mem_stall;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state           <= HZ_RUN;
      flush_pend      <= 1'b0;
      wait_cnt        <= '0;
      stall_cnt       <= '0;
      flush_cnt       <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      state      <= state_n;
      flush_pend <= fp_n;
      wait_cnt   <= wc_n;
      if (state == HZ_MEM_WAIT && mem_stall && wait_cnt == TO) mem_timeout_err <= 1'b1;
      stall_cnt  <= stall_cnt + CNT_W'(pc_hold & ~&stall_cnt);
      flush_cnt  <= flush_cnt + CNT_W'(if_id_flush & ~&flush_cnt);
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed + randomized checks of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
  localparam int CW = 4;
  localparam int TO = 4;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic u1 = 0, u2 = 0, mr = 0, redir = 0, req = 0, rdy = 0;
  logic pc_hold, if_id_hold, if_id_flush, id_ex_bubble, ex_mem_hold, mem_wb_bubble, err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0;
  bit m_wait, m_fdue, m_owed, m_err;
  int m_wc, m_sc, m_fc;
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs1_addr(rs1), .ID_rs2_addr(rs2), .ID_uses_rs1(u1), .ID_uses_rs2(u2),
    .EX_mem_read(mr), .EX_reg_addr(rd), .EX_redirect(redir),
    .MEM_req(req), .MEM_ready(rdy),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_hold(ex_mem_hold), .mem_wb_bubble(mem_wb_bubble),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout_err(err)
  );
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  function automatic logic [5:0] strobes();
    return {pc_hold, if_id_hold, if_id_flush, id_ex_bubble, ex_mem_hold, mem_wb_bubble};
  endfunction
  task automatic model_reset();
    m_wait = 0; m_fdue = 0; m_owed = 0; m_err = 0; m_wc = 0; m_sc = 0; m_fc = 0;
  endtask
  task automatic regs_chk(input string tag);
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(m_sc));
    chk({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(m_fc));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
  endtask
  task automatic cyc(input string tag, input bit i_u1, i_u2, i_mr, i_redir, i_req, i_rdy,
                     input logic [4:0] a1, a2, d);
    bit stall, lu, fl, lus, hold;
    u1 = i_u1; u2 = i_u2; mr = i_mr; redir = i_redir; req = i_req; rdy = i_rdy;
    rs1 = a1; rs2 = a2; rd = d;
    #3;
    stall = i_req && !i_rdy;
    lu = i_mr && d != 0 && ((i_u1 && a1 == d) || (i_u2 && a2 == d));
    fl = !stall && !m_wait && (i_redir || m_fdue);
    lus = !stall && !m_wait && !m_fdue && !i_redir && lu;
    hold = stall || lus;
    chk({tag, "_strobes"}, 32'(strobes()), 32'({hold, hold, fl, fl || lus, stall, stall}));
    regs_chk(tag);
    @(posedge clk);
    if (m_wait && stall) begin
      if (m_wc == TO) m_err = 1;
      if (m_wc < TO) m_wc++;
    end else m_wc = 0;
    if (hold && m_sc < SAT) m_sc++;
    if (fl && m_fc < SAT) m_fc++;
    m_fdue = !stall && m_wait && (m_owed || i_redir);
    m_owed = (stall || m_wait) ? (m_owed || i_redir) : 1'b0;
    m_wait = stall;
    #1;
  endtask
  task automatic do_reset(input string tag);
    u1 = 0; u2 = 0; mr = 0; redir = 0; req = 0; rdy = 0;
    rst_n = 1'b0;
    #2;
    model_reset();
    chk({tag, "_rst_strobes"}, 32'(strobes()), 32'd0);
    regs_chk({tag, "_rst"});
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    model_reset();
    #12;
    chk("reset_strobes", 32'(strobes()), 32'd0);
    regs_chk("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("lu_x5", 1, 1, 1, 0, 0, 0, 5'd5, 5'd1, 5'd5);
    cyc("lu_after", 1, 1, 0, 0, 0, 0, 5'd5, 5'd1, 5'd5);
    chk("lu_stall_cnt_is_1", 32'(stall_cnt), 32'd1);
    cyc("lu_both", 1, 1, 1, 0, 0, 0, 5'd7, 5'd7, 5'd7);
    cyc("lu_x0", 1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    cyc("lu_unused", 0, 0, 1, 0, 0, 0, 5'd9, 5'd9, 5'd9);
    do_reset("r1");
    cyc("redir_lu", 1, 1, 1, 1, 0, 0, 5'd5, 5'd5, 5'd5);
    cyc("redir_after", 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("redir_flush_cnt_is_1", 32'(flush_cnt), 32'd1);
    chk("redir_stall_cnt_is_0", 32'(stall_cnt), 32'd0);
    do_reset("r2");
    for (int i = 0; i < 3; i++) cyc("memw", 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    cyc("memw_rdy", 1, 0, 1, 0, 1, 1, 5'd3, 5'd0, 5'd4);
    chk("memw_stall_cnt_is_3", 32'(stall_cnt), 32'd3);
    do_reset("r3");
    cyc("fp_w0", 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    cyc("fp_w1", 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    cyc("fp_w2", 0, 0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
    cyc("fp_rdy", 0, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0);
    cyc("fp_flush", 1, 0, 1, 0, 0, 0, 5'd2, 5'd0, 5'd2);
    cyc("fp_idle", 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("fp_flush_cnt_is_1", 32'(flush_cnt), 32'd1);
    do_reset("r4");
    for (int i = 0; i < 5; i++) cyc("to", 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    chk("to_err_not_yet", 32'(err), 32'd0);
    cyc("to_5th", 0, 0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
    chk("to_err_set", 32'(err), 32'd1);
    cyc("to_sticky", 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    do_reset("to_rst");
    cyc("to_post_rst", 1, 0, 1, 1, 0, 0, 5'd1, 5'd0, 5'd1);
    chk("to_post_rst_flush_cnt", 32'(flush_cnt), 32'd1);
    do_reset("r5");
    for (int i = 0; i < SAT + 4; i++) cyc("sat", 1, 0, 1, 0, 0, 0, 5'd6, 5'd0, 5'd6);
    chk("sat_stall_cnt", 32'(stall_cnt), 32'hF);
    do_reset("r6");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
      cyc("rnd", 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 5) == 0,
          1'($urandom), $urandom_range(0, 3) == 0,
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
